// File: rtl/disp_seq_pkg.sv
// Shared types and helpers for the display frame sequencer.
package disp_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SWAP     = 2'd1,
        ST_DISPATCH = 2'd2,
        ST_RUN      = 2'd3
    } seq_state_t;

    // Width of a job index; never narrower than one bit so a single-job build still has a port.
    function automatic int SEQ_IDX_W(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/disp_seq_pick.sv
// Lowest-set-bit encoder used to choose the next render job from the pending mask.
module disp_seq_pick
    import disp_seq_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]               mask,
    output logic [SEQ_IDX_W(N)-1:0]    idx,
    output logic                       any
);

    localparam int IW = SEQ_IDX_W(N);

    // Scan from the top so the lowest set bit is the final, winning assignment.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = IW'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/disp_sequencer.sv
// Frame scheduler: one buffer swap per frame, then each enabled render job in index
// order through a start/done handshake, with a per-step watchdog and a frame counter.
module disp_sequencer
    import disp_seq_pkg::*;
#(
    parameter int N  = 4,
    parameter int TW = 24,
    parameter int FW = 16
) (
    input  logic                       clkSYS,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [N-1:0]               job_en,
    input  logic [TW-1:0]              timeout_max,
    input  logic                       err_clr,
    output logic                       swap_start,
    input  logic                       swap_done,
    output logic [N-1:0]               start,
    input  logic [N-1:0]               done,
    output logic                       busy,
    output logic [SEQ_IDX_W(N)-1:0]    job_idx,
    output logic [FW-1:0]              frame_cnt,
    output logic [N:0]                 err_timeout
);

    localparam int IW = SEQ_IDX_W(N);

    seq_state_t        state_q, state_d;
    logic [N-1:0]      mask_q, mask_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              swap_start_q, swap_start_d;
    logic [N-1:0]      start_q, start_d;
    logic              busy_q, busy_d;
    logic [IW-1:0]     job_idx_q, job_idx_d;
    logic [FW-1:0]     frame_cnt_q, frame_cnt_d;
    logic [N:0]        err_q, err_d;

    logic [IW-1:0]     pick_idx;
    logic              pick_any;

    logic              swap_ack;
    logic              job_ack;
    logic              tmo_hit;
    logic              swap_tmo;
    logic              job_tmo;

    disp_seq_pick #(.N(N)) u_pick (
        .mask (mask_q),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // A completion is only honoured in its wait state and never in the cycle of its own start pulse.
    assign swap_ack = (state_q == ST_SWAP) && swap_done && !swap_start_q;
    assign job_ack  = (state_q == ST_RUN) && done[job_idx_q] && !start_q[job_idx_q];

    // Watchdog fires only when enabled and no valid completion is present; done wins a tie.
    assign tmo_hit  = (timeout_max != '0) && (timer_q == timeout_max);
    assign swap_tmo = (state_q == ST_SWAP) && tmo_hit && !swap_ack;
    assign job_tmo  = (state_q == ST_RUN) && tmo_hit && !job_ack;

    // Next-state logic: swap, then dispatch jobs one at a time, then close the frame.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_SWAP;
            end
            ST_SWAP: begin
                if (swap_ack || swap_tmo) state_d = ST_DISPATCH;
            end
            ST_DISPATCH: begin
                if (pick_any)    state_d = ST_RUN;
                else if (enable) state_d = ST_SWAP;
                else             state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (job_ack || job_tmo) state_d = ST_DISPATCH;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered outputs, pending mask, watchdog timer and sticky error flags.
    always_comb begin
        swap_start_d = (state_q != ST_SWAP) && (state_d == ST_SWAP);
        start_d      = '0;
        busy_d       = (state_d != ST_IDLE);
        job_idx_d    = job_idx_q;
        frame_cnt_d  = frame_cnt_q;
        mask_d       = mask_q;
        timer_d      = timer_q;
        err_d        = err_q;

        if ((state_q == ST_SWAP) && (state_d == ST_DISPATCH)) begin
            mask_d = job_en;
        end

        if (state_q == ST_DISPATCH) begin
            if (pick_any) begin
                start_d[pick_idx] = 1'b1;
                mask_d[pick_idx]  = 1'b0;
                job_idx_d         = pick_idx;
            end else begin
                frame_cnt_d = frame_cnt_q + FW'(1);
            end
        end

        // Timer restarts on every entry into a wait state and saturates instead of wrapping.
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (((state_q == ST_SWAP) || (state_q == ST_RUN)) && (timer_q != '1)) begin
            timer_d = timer_q + TW'(1);
        end

        // Clear first so a timeout in the same cycle still leaves its bit set.
        if (err_clr) err_d = '0;
        if (swap_tmo) err_d[N] = 1'b1;
        if (job_tmo)  err_d[job_idx_q] = 1'b1;
    end

    // State and register bank; reset forces everything back to zero immediately.
    always_ff @(posedge clkSYS or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            mask_q       <= '0;
            timer_q      <= '0;
            swap_start_q <= 1'b0;
            start_q      <= '0;
            busy_q       <= 1'b0;
            job_idx_q    <= '0;
            frame_cnt_q  <= '0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            timer_q      <= timer_d;
            swap_start_q <= swap_start_d;
            start_q      <= start_d;
            busy_q       <= busy_d;
            job_idx_q    <= job_idx_d;
            frame_cnt_q  <= frame_cnt_d;
            err_q        <= err_d;
        end
    end

    assign swap_start  = swap_start_q;
    assign start       = start_q;
    assign busy        = busy_q;
    assign job_idx     = job_idx_q;
    assign frame_cnt   = frame_cnt_q;
    assign err_timeout = err_q;

endmodule
